// File: rtl/bank_isu_credit_pool_pkg.sv
// Shared definitions for the bank issue-queue read-credit pool.
package bank_isu_pkg;

    localparam int CHANNEL_NUM_DEF = 32'sd4;
    localparam int PTR_WIDTH_DEF   = 32'sd8;
    localparam int CREDIT_INIT_DEF = 32'sd8;

    // Channel-id width; a single channel still needs a one-bit id port.
    function automatic int ch_w_f(input int ch_num);
        return (ch_num > 32'sd1) ? $clog2(ch_num) : 32'sd1;
    endfunction

    // Credit counter width able to hold 0..credit_init.
    function automatic int cnt_w_f(input int credit_init);
        return $clog2(credit_init + 32'sd1);
    endfunction

    localparam int CH_W  = ch_w_f(CHANNEL_NUM_DEF);
    localparam int CNT_W = cnt_w_f(CREDIT_INIT_DEF);

    typedef logic [PTR_WIDTH_DEF-1:0] iq_ptr_t;

    localparam int ERR_PEND_OVF = 32'sd0;
    localparam int ERR_CRED_OVF = 32'sd1;

endpackage

// File: rtl/bank_isu_credit_pool_fifo.sv
// In-order pending FIFO for IQ slots waiting on a channel credit.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only when a pop happens in the same cycle.
module credit_pend_fifo
    import bank_isu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer update; flush empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/bank_isu_credit_pool.sv
// Per-channel read-credit manager for the bank issue queue. Reads either take
// a credit on enqueue or park in a per-channel FIFO and are granted oldest-first
// as credits return. Non-read ops are allowed to issue immediately.
module bank_isu_credit_pool
    import bank_isu_pkg::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int PTR_WIDTH   = 8,
    parameter int CREDIT_INIT = 8,
    parameter int PEND_DEPTH  = 16,
    localparam int DEPTH      = 1 << PTR_WIDTH,
    localparam int CH_W_P     = ch_w_f(CHANNEL_NUM),
    localparam int CNT_W_P    = cnt_w_f(CREDIT_INIT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iq_enqueue,
    input  logic [PTR_WIDTH-1:0]         iq_write_ptr,
    input  logic                         htu_op_is_read,
    input  logic [CH_W_P-1:0]            htu_ch_id,
    input  logic                         iq_dequeue,
    input  logic [PTR_WIDTH-1:0]         iq_dequeue_ptr,
    input  logic                         iq_flush,
    input  logic [CHANNEL_NUM-1:0]       channels_credit_release,
    output logic [DEPTH-1:0]             credit_allow_array,
    output logic [CHANNEL_NUM-1:0]       channels_pend_full,
    output logic [CHANNEL_NUM*CNT_W_P-1:0] channels_credit_num,
    output logic [1:0]                   err_sticky
);
    logic [DEPTH-1:0]                       allow_r;
    logic [DEPTH-1:0]                       allow_next_s;
    logic [1:0]                             err_r;
    logic [1:0]                             err_next_s;
    logic [CHANNEL_NUM-1:0]                 enq_rd_s;
    logic [CHANNEL_NUM-1:0]                 pop_s;
    logic [CHANNEL_NUM-1:0]                 imm_s;
    logic [CHANNEL_NUM-1:0]                 push_s;
    logic [CHANNEL_NUM-1:0]                 drop_s;
    logic [CHANNEL_NUM-1:0]                 cred_ovf_s;
    logic [CHANNEL_NUM-1:0]                 empty_s;
    logic [CHANNEL_NUM-1:0]                 full_s;
    logic [CHANNEL_NUM-1:0][PTR_WIDTH-1:0]  head_s;

    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
        logic [CNT_W_P-1:0] credit_r;
        logic               has_credit_s;
        logic               dec_s;

        assign has_credit_s = (credit_r != '0);
        assign enq_rd_s[c]  = iq_enqueue && htu_op_is_read && !iq_flush && (int'(htu_ch_id) == c);
        // Parked ops are served before any new arrival, so a grant needs a non-empty FIFO.
        assign pop_s[c]     = !empty_s[c] && has_credit_s && !iq_flush;
        assign imm_s[c]     = enq_rd_s[c] && empty_s[c] && has_credit_s;
        assign push_s[c]    = enq_rd_s[c] && !imm_s[c] && (!full_s[c] || pop_s[c]);
        assign drop_s[c]    = enq_rd_s[c] && !imm_s[c] && full_s[c] && !pop_s[c];
        assign dec_s        = imm_s[c] || pop_s[c];
        assign cred_ovf_s[c] = channels_credit_release[c] && !dec_s &&
                               (credit_r == CNT_W_P'(CREDIT_INIT));

        credit_pend_fifo #(
            .WIDTH (PTR_WIDTH),
            .DEPTH (PEND_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_s[c]),
            .pop   (pop_s[c]),
            .flush (iq_flush),
            .din   (iq_write_ptr),
            .head  (head_s[c]),
            .full  (full_s[c]),
            .empty (empty_s[c])
        );

        // Credit counter: take on grant, return on release, saturate at the pool size
        always_ff @(posedge clk) begin
            if (rst) begin
                credit_r <= CNT_W_P'(CREDIT_INIT);
            end else if (cred_ovf_s[c]) begin
                credit_r <= credit_r;
            end else begin
                credit_r <= credit_r - CNT_W_P'(dec_s) + CNT_W_P'(channels_credit_release[c]);
            end
        end

        assign channels_credit_num[c*CNT_W_P +: CNT_W_P] = credit_r;
    end

    // Allow-array next state: hold, dequeue clears, enqueue/grant sets, flush wipes
    always_comb begin
        allow_next_s = allow_r;
        if (iq_dequeue) begin
            allow_next_s[iq_dequeue_ptr] = 1'b0;
        end else begin
            allow_next_s = allow_r;
        end
        if (iq_enqueue && !iq_flush) begin
            allow_next_s[iq_write_ptr] = !htu_op_is_read || (|imm_s);
        end else begin
            allow_next_s = allow_next_s;
        end
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            if (pop_s[c]) begin
                allow_next_s[head_s[c]] = 1'b1;
            end else begin
                allow_next_s = allow_next_s;
            end
        end
        if (iq_flush) begin
            allow_next_s = '0;
        end else begin
            allow_next_s = allow_next_s;
        end
    end

    // Sticky error flags accumulate until reset
    always_comb begin
        err_next_s               = err_r;
        err_next_s[ERR_PEND_OVF] = err_r[ERR_PEND_OVF] | (|drop_s);
        err_next_s[ERR_CRED_OVF] = err_r[ERR_CRED_OVF] | (|cred_ovf_s);
    end

    // Output state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            allow_r <= '0;
            err_r   <= 2'b00;
        end else begin
            allow_r <= allow_next_s;
            err_r   <= err_next_s;
        end
    end

    assign credit_allow_array = allow_r;
    assign err_sticky         = err_r;
    assign channels_pend_full = full_s;

endmodule

// File: tb/tb_bank_isu_credit_pool.sv
// Scoreboard bench for bank_isu_credit_pool: a queue-based reference model
// predicts the full output state after every clock; a monitor compares at negedge.
module tb_bank_isu_credit_pool;

    localparam int NCH  = 4;
    localparam int INIT = 8;
    localparam int PD   = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iq_enqueue = 1'b0;
    logic [7:0]   iq_write_ptr = 8'd0;
    logic         htu_op_is_read = 1'b0;
    logic [1:0]   htu_ch_id = 2'd0;
    logic         iq_dequeue = 1'b0;
    logic [7:0]   iq_dequeue_ptr = 8'd0;
    logic         iq_flush = 1'b0;
    logic [3:0]   channels_credit_release = 4'd0;
    logic [255:0] credit_allow_array;
    logic [3:0]   channels_pend_full;
    logic [15:0]  channels_credit_num;
    logic [1:0]   err_sticky;

    bank_isu_credit_pool dut (
        .clk                     (clk),
        .rst                     (rst),
        .iq_enqueue              (iq_enqueue),
        .iq_write_ptr            (iq_write_ptr),
        .htu_op_is_read          (htu_op_is_read),
        .htu_ch_id               (htu_ch_id),
        .iq_dequeue              (iq_dequeue),
        .iq_dequeue_ptr          (iq_dequeue_ptr),
        .iq_flush                (iq_flush),
        .channels_credit_release (channels_credit_release),
        .credit_allow_array      (credit_allow_array),
        .channels_pend_full      (channels_pend_full),
        .channels_credit_num     (channels_credit_num),
        .err_sticky              (err_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct { int ch; int slot; } park_t;
    typedef struct {
        logic [255:0] allow;
        logic [3:0]   full;
        logic [15:0]  cred;
        logic [1:0]   err;
        int           due;
    } exp_t;

    park_t    m_park[$];     // all parked ops in arrival order
    int       m_credit[NCH];
    bit [255:0] m_allow;
    bit [1:0] m_err;
    exp_t     sb_q[$];

    int checks = 0;
    int passes = 0;

    function automatic int pend_size(input int ch);
        int n = 0;
        foreach (m_park[i]) if (m_park[i].ch == ch) n++;
        return n;
    endfunction

    function automatic int pend_head_idx(input int ch);
        foreach (m_park[i]) if (m_park[i].ch == ch) return i;
        return -1;
    endfunction

    function automatic bit is_parked(input int slot);
        foreach (m_park[i]) if (m_park[i].slot == slot) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_expect(input int due);
        exp_t e;
        e.allow = m_allow;
        e.err   = m_err;
        for (int c = 0; c < NCH; c++) begin
            e.full[c]        = (pend_size(c) == PD);
            e.cred[c*4 +: 4] = m_credit[c][3:0];
        end
        e.due = due;
        sb_q.push_back(e);
    endtask

    task automatic model_reset();
        m_park.delete();
        for (int c = 0; c < NCH; c++) m_credit[c] = INIT;
        m_allow = '0;
        m_err   = 2'b00;
    endtask

    // Apply one cycle of inputs to the model.
    task automatic model_cycle(input bit enq, input int wptr, input bit rd, input int ch,
                               input bit deq, input int dptr, input bit fl, input bit [3:0] rel);
        bit [255:0] nxt;
        int  sz[NCH];
        bit  pop[NCH];
        bit  dec[NCH];
        int  head[NCH];
        nxt = m_allow;
        for (int c = 0; c < NCH; c++) begin
            sz[c] = pend_size(c); pop[c] = 1'b0; dec[c] = 1'b0; head[c] = 0;
        end
        if (deq) nxt[dptr] = 1'b0;
        if (!fl) begin
            for (int c = 0; c < NCH; c++) begin
                if (sz[c] > 0 && m_credit[c] > 0) begin
                    pop[c] = 1'b1; dec[c] = 1'b1;
                    head[c] = m_park[pend_head_idx(c)].slot;
                end
            end
            if (enq) begin
                if (!rd) nxt[wptr] = 1'b1;
                else if (sz[ch] == 0 && m_credit[ch] > 0) begin
                    nxt[wptr] = 1'b1; dec[ch] = 1'b1;
                end else begin
                    nxt[wptr] = 1'b0;
                    if (sz[ch] < PD || pop[ch]) m_park.push_back('{ch, wptr});
                    else m_err[0] = 1'b1;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (pop[c]) begin
                    m_park.delete(pend_head_idx(c));
                    nxt[head[c]] = 1'b1;
                end
            end
        end else begin
            m_park.delete();
            nxt = '0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (rel[c] && !dec[c] && m_credit[c] == INIT) m_err[1] = 1'b1;
            else m_credit[c] = m_credit[c] + int'(rel[c]) - int'(dec[c]);
        end
        m_allow = nxt;
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit enq, input int wptr, input bit rd, input int ch,
                        input bit deq, input int dptr, input bit fl, input bit [3:0] rel);
        rst = 1'b0;
        iq_enqueue = enq; iq_write_ptr = wptr[7:0]; htu_op_is_read = rd; htu_ch_id = ch[1:0];
        iq_dequeue = deq; iq_dequeue_ptr = dptr[7:0]; iq_flush = fl;
        channels_credit_release = rel;
        model_cycle(enq, wptr, rd, ch, deq, dptr, fl, rel);
        push_expect(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic rd_op(input int slot, input int ch);
        step(1, slot, 1, ch, 0, 0, 0, 4'd0);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            chk("allow_array", credit_allow_array, e.allow);
            chk("pend_full", 256'(channels_pend_full), 256'(e.full));
            chk("credit_num", 256'(channels_credit_num), 256'(e.cred));
            chk("err_sticky", 256'(err_sticky), 256'(e.err));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wp;
        bit [3:0] rl;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        push_expect(cyc);

        // 8 reads take all ch0 credits, the 9th parks
        for (int i = 0; i < 9; i++) rd_op(i, 0);
        idle(1);
        // single release grants slot 8 two cycles later
        step(0, 0, 0, 0, 0, 0, 0, 4'b0001);
        idle(3);
        // three parked ops granted in order by back-to-back releases
        for (int i = 9; i < 12; i++) rd_op(i, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 4'b0001);
        idle(3);
        // ch1: pop of head and new read in the same cycle
        for (int i = 20; i < 29; i++) rd_op(i, 1);
        step(0, 0, 0, 0, 0, 0, 0, 4'b0010);
        rd_op(29, 1);
        idle(3);
        // ch2: fill pending FIFO, overflow, then flush
        for (int i = 40; i < 64; i++) rd_op(i, 2);
        idle(1);
        rd_op(64, 2);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1, 4'd0);
        idle(2);
        // ch3 release at full pool, dequeue clear, dequeue vs set on same slot
        step(0, 0, 0, 0, 0, 0, 0, 4'b1000);
        step(1, 100, 0, 0, 0, 0, 0, 4'd0);
        step(0, 0, 0, 0, 1, 100, 0, 4'd0);
        step(1, 101, 0, 0, 1, 101, 0, 4'd0);
        idle(2);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            do wp = $urandom_range(0, 255); while (is_parked(wp));
            for (int c = 0; c < NCH; c++) rl[c] = ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 3) != 0, wp, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 255),
                 $urandom_range(0, 99) == 0, rl);
        end
        idle(2);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
